fifoc2cmd: RTL

Command-frame reader for the receive path. On a start request it drains one UDP payload from the command FIFO (fifoc, read side in sys_clk) and validates it as a fixed 12-byte command frame. It then commits the nine command bytes to the cmd_* registers consumed by the ADC control logic. It is the sys_clk-side consumer of the bytes mac2fifoc writes on gmii_rxc, and it closes the fs/fd handshake with the top-level sequencer.

---
 rtl/fifoc2cmd_pkg.sv | 19 +
 rtl/fifoc2cmd.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifoc2cmd_pkg.sv
// fifoc2cmd shared types and constants.
// Frame geometry, header bytes and FSM state encoding.
package fifoc2cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    CHECK,
    DONE
  } state_t;

  localparam int FRAME_LEN = 12;
  localparam int CMD_BYTES = 9;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

endpackage

// File: rtl/fifoc2cmd.sv
// fifoc2cmd: drains one payload from fifoc and commits cmd_* on a valid frame.
// Define FIFOC2CMD_CHECKSUM_EN to require byte 11 == XOR of bytes 2..10.
module fifoc2cmd
  import fifoc2cmd_pkg::*;
(
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] data_len,
  output logic        fifoc_rxen,
  input  logic [7:0]  fifoc_rxd,
  output logic [7:0]  cmd_kdev,
  output logic [7:0]  cmd_smpr,
  output logic [7:0]  cmd_filt,
  output logic [7:0]  cmd_mix0,
  output logic [7:0]  cmd_mix1,
  output logic [7:0]  cmd_reg4,
  output logic [7:0]  cmd_reg5,
  output logic [7:0]  cmd_reg6,
  output logic [7:0]  cmd_reg7,
  output logic        err
);

  localparam logic [11:0] LEN_OK = 12'(FRAME_LEN);

  state_t state, nxt;

  logic [11:0] len_r;
  logic [11:0] cnt;
  logic        cap_v;
  logic [3:0]  cap_idx;
  logic        hdr_ok;
  logic        sum_ok;
  logic        valid;
  logic        err_r;

  logic [FRAME_LEN-1:0][7:0] shadow;
  logic [CMD_BYTES-1:0][7:0] cmd;

  // next-state decode; strobes follow the state directly
  always_comb begin
    nxt        = state;
    fifoc_rxen = 1'b0;
    fd         = 1'b0;
    unique case (state)
      IDLE: begin
        if (fs) begin
          nxt = (data_len == 12'd0) ? LAST : READ;
        end
      end
      READ: begin
        fifoc_rxen = 1'b1;
        if (cnt == len_r - 12'd1) begin
          nxt = LAST;
        end
      end
      LAST:  nxt = CHECK;
      CHECK: nxt = DONE;
      DONE: begin
        fd = 1'b1;
        if (!fs) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // state register, length latch and read counter
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_r <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && fs) begin
        len_r <= data_len;
        cnt   <= '0;
      end else if (fifoc_rxen) begin
        cnt <= cnt + 12'd1;
      end
    end
  end

  // read data lands one cycle after rxen; only bytes 0..11 are kept
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cap_v   <= 1'b0;
      cap_idx <= '0;
      shadow  <= '0;
    end else begin
      cap_v   <= fifoc_rxen && (cnt < LEN_OK);
      cap_idx <= cnt[3:0];
      if (cap_v) begin
        shadow[cap_idx] <= fifoc_rxd;
      end
    end
  end

  assign hdr_ok = (shadow[0] == HDR0) && (shadow[1] == HDR1);

`ifdef FIFOC2CMD_CHECKSUM_EN
  logic [7:0] xacc;

  // running XOR over the nine command bytes
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      xacc <= '0;
    end else if (state == IDLE && fs) begin
      xacc <= '0;
    end else if (cap_v && cap_idx >= 4'd2 && cap_idx <= 4'd10) begin
      xacc <= xacc ^ fifoc_rxd;
    end
  end

  assign sum_ok = (shadow[11] == xacc);
`else
  logic unused_sum;

  assign unused_sum = ^shadow[11];
  assign sum_ok     = 1'b1;
`endif

  assign valid = (len_r == LEN_OK) && hdr_ok && sum_ok;

  // commit or reject once the whole frame has been captured
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cmd   <= '0;
      err_r <= 1'b0;
    end else if (state == CHECK) begin
      if (valid) begin
        cmd <= shadow[10:2];
      end
      err_r <= ~valid;
    end
  end

  assign err      = err_r;
  assign cmd_kdev = cmd[0];
  assign cmd_smpr = cmd[1];
  assign cmd_filt = cmd[2];
  assign cmd_mix0 = cmd[3];
  assign cmd_mix1 = cmd[4];
  assign cmd_reg4 = cmd[5];
  assign cmd_reg5 = cmd[6];
  assign cmd_reg6 = cmd[7];
  assign cmd_reg7 = cmd[8];

endmodule
